pokey_clock_scheduler: RTL and testbench
========================================

# pokey_clock_scheduler

Generates the per-channel clock-enable strobes and synchronous clear for the POKEY timer channels and their latch/delay lines. It divides the 1.79 MHz `ce` tick into the 64 kHz and 15 kHz base ticks and selects each channel's clock source from AUDCTL. It also handles two-channel join mode and holds off the delay lines during SKCTL init and STIMER writes. It sits between the POKEY register file and the four channel timer/delay-line instances.

## Interface
- `DIV_64`, default 28: `ce` ticks per 64 kHz base tick.
- `DIV_15`, default 114: `ce` ticks per 15 kHz base tick.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset. The block has one clock; reset is synchronous and active-low.
- `ce`, in, 1: 1.79 MHz clock enable, one `clk` wide.
- `init_mode`, in, 1: high when SKCTL[1:0] == 00.
- `audctl`, in, 8: AUDCTL register. Bit0 selects the 15 kHz base. Bit6 runs ch0 at 1.79 MHz. Bit5 runs ch2 at 1.79 MHz. Bit4 joins ch0→ch1. Bit3 joins ch2→ch3.
- `stimer_wr`, in, 1: one-`clk` pulse on an STIMER write.
- `underflow`, in, 4: delay-line outputs, one per channel; bit i is channel i.
- `tick_64`, out, 1: 64 kHz tick, qualified with `ce`.
- `tick_15`, out, 1: 15 kHz tick, qualified with `ce`.
- `base_tick`, out, 1: `tick_15` if `audctl[0]`, else `tick_64`.
- `chan_enable`, out, 4: per-channel decrement/shift enable.
- `delay_sync_reset`, out, 1: synchronous clear to all delay lines and timers.

## Operation
- Counter `cnt64`, `clog2(DIV_64)` bits:
  - increments on `ce`.
  - wraps DIV_64-1 → 0.
  - `tick_64 = ce & (cnt64 == DIV_64-1) & ~init_mode`.
- Counter `cnt15`: same structure, using DIV_15.
- While `init_mode` = 1:
  - both counters are held at 0 (synchronous, independent of `ce`).
  - all ticks and `chan_enable` are 0.
  - `delay_sync_reset` = 1.
- `chan_enable` selection (every term is ANDed with `ce & ~init_mode`):
  - ch0: `audctl[6] ? 1 : base_tick`.
  - ch1: `audctl[4] ? underflow[0] : base_tick`.
  - ch2: `audctl[5] ? 1 : base_tick`.
  - ch3: `audctl[3] ? underflow[2] : base_tick`.
- STIMER handshake:
  - `stimer_wr` sets the `stim_pend` flag.
  - `delay_sync_reset = init_mode | stim_pend`.
  - `stim_pend` clears on the first `clk` with `ce` = 1 after being set. The set takes priority if `stimer_wr` and `ce` coincide; in that case it clears at the next `ce`.
  - While `stim_pend` = 1, `chan_enable` is forced to 0. The divider counters keep running; STIMER does not reset them.
- `audctl` changes take effect combinationally on the next `ce`. No resynchronisation.

## Timing
- Reset (`reset_n` = 0 at a `clk` edge):
  - `cnt64`, `cnt15`, `stim_pend` ← 0.
  - While `reset_n` = 0, all outputs are forced to 0 combinationally, except `delay_sync_reset`, which is 1.
- The first `tick_64` comes on the DIV_64-th `ce` after reset or init release. The first `tick_15` comes on the DIV_15-th such `ce`.
- All outputs are combinational from registered state plus `ce`/`audctl`/`underflow`. They are valid in the same `clk` as `ce`; zero added latency.
- Join mode: ch1 enable is active in the same `clk` as `underflow[0]`, with no extra cycle.
- `stimer_wr` → `delay_sync_reset` high from the next `clk`, lasting until and including the next `ce` cycle.
- Init release takes effect at the next clk. Counters start from 0 on the first `ce` with `init_mode` = 0.
- Wrap is exact. Period is DIV_64 / DIV_15 `ce` ticks regardless of the `ce` spacing in `clk` cycles.

## Test plan
- Base ticks: reset, `ce` every 2 clk, `audctl` = 0 → `tick_64` every 28 `ce`, `tick_15` every 114 `ce`, `chan_enable` = 4'b1111 on each `tick_64`, 0 otherwise.
- Source select: `audctl` = 0x61 → `chan_enable[0]` and `chan_enable[2]` on every `ce`; `chan_enable[1]` and `chan_enable[3]` only on `tick_15`.
- Join: `audctl` = 0x58, pulse `underflow[0]` on a `ce` → `chan_enable[1]` high that same clk. `underflow[0]` without `ce` → no enable.
- STIMER: `stimer_wr` 3 clk before a `ce` that coincides with `tick_64` → `delay_sync_reset` high 3 clk, `chan_enable` = 0 on that `ce`. Next `tick_64` still arrives 28 `ce` later.
- Init: `init_mode` = 1 for 50 `ce`, then 0 → no ticks during init, `delay_sync_reset` = 1; first `tick_64` on the 28th `ce` after release.
- Reset mid-count: assert `reset_n` = 0 at `cnt64` = 17 → counters 0, outputs 0, `delay_sync_reset` = 1. After release, the first tick comes 28 `ce` later.

Source files
------------

// File: rtl/pokey_clock_scheduler_if.sv
// Bus between the POKEY register file (master) and the clock scheduler (slave).
// Carries the 1.79 MHz enable, control registers, delay-line feedback and
// the generated tick / enable / clear strobes.
interface pokey_clock_scheduler_if;
  logic       ce;
  logic       init_mode;
  logic [7:0] audctl;
  logic       stimer_wr;
  logic [3:0] underflow;
  logic       tick_64;
  logic       tick_15;
  logic       base_tick;
  logic [3:0] chan_enable;
  logic       delay_sync_reset;

  modport master (
    output ce, init_mode, audctl, stimer_wr, underflow,
    input  tick_64, tick_15, base_tick, chan_enable, delay_sync_reset
  );

  modport slave (
    input  ce, init_mode, audctl, stimer_wr, underflow,
    output tick_64, tick_15, base_tick, chan_enable, delay_sync_reset
  );
endinterface

// File: rtl/pokey_clock_scheduler.sv
// POKEY clock scheduler: divides ce into 64 kHz / 15 kHz base ticks, picks each
// timer channel's clock source from AUDCTL (including two-channel join) and
// holds the delay lines in clear during SKCTL init and after STIMER writes.
module pokey_clock_scheduler #(
  parameter int unsigned DIV_64 = 28,
  parameter int unsigned DIV_15 = 114
) (
  input logic                    clk,
  input logic                    reset_n,
  pokey_clock_scheduler_if.slave bus
);

  localparam int unsigned W64 = (DIV_64 > 1) ? $clog2(DIV_64) : 1;
  localparam int unsigned W15 = (DIV_15 > 1) ? $clog2(DIV_15) : 1;
  localparam logic [W64-1:0] MAX64 = W64'(DIV_64 - 1);
  localparam logic [W15-1:0] MAX15 = W15'(DIV_15 - 1);

  logic [W64-1:0] cnt64;
  logic [W15-1:0] cnt15;
  logic           stim_pend;

  logic       active;
  logic       tick_64;
  logic       tick_15;
  logic       base_tick;
  logic [3:0] chan_enable;
  logic       delay_sync_reset;

  logic unused_audctl;
  assign unused_audctl = ^{bus.audctl[7], bus.audctl[2:1]};

  // Base-tick dividers: held at zero during init, otherwise advance on ce and wrap.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.init_mode) begin
      cnt64 <= '0;
      cnt15 <= '0;
    end else if (bus.ce) begin
      cnt64 <= (cnt64 == MAX64) ? '0 : cnt64 + W64'(1);
      cnt15 <= (cnt15 == MAX15) ? '0 : cnt15 + W15'(1);
    end
  end

  // STIMER pending flag: set by a write (wins over ce), cleared by the next ce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stim_pend <= 1'b0;
    end else if (bus.stimer_wr) begin
      stim_pend <= 1'b1;
    end else if (bus.ce) begin
      stim_pend <= 1'b0;
    end
  end

  // Output strobes: combinational from counters, ce, AUDCTL and underflow.
  always_comb begin
    tick_64          = 1'b0;
    tick_15          = 1'b0;
    base_tick        = 1'b0;
    chan_enable      = '0;
    delay_sync_reset = 1'b1;
    active           = bus.ce & ~bus.init_mode;
    if (reset_n) begin
      tick_64     = active & (cnt64 == MAX64);
      tick_15     = active & (cnt15 == MAX15);
      base_tick   = bus.audctl[0] ? tick_15 : tick_64;
      chan_enable = {bus.audctl[3] ? bus.underflow[2] : base_tick,
                     bus.audctl[5] ? 1'b1             : base_tick,
                     bus.audctl[4] ? bus.underflow[0] : base_tick,
                     bus.audctl[6] ? 1'b1             : base_tick}
                    & {4{active & ~stim_pend}};
      delay_sync_reset = bus.init_mode | stim_pend;
    end
  end

  assign bus.tick_64          = tick_64;
  assign bus.tick_15          = tick_15;
  assign bus.base_tick        = base_tick;
  assign bus.chan_enable      = chan_enable;
  assign bus.delay_sync_reset = delay_sync_reset;

endmodule

// File: tb/tb_pokey_clock_scheduler.sv
// Scoreboard bench for pokey_clock_scheduler: the stimulus process pushes the
// expected output vector for every clk it drives; a monitor pops and compares
// at the falling edge of the same clk.
module tb_pokey_clock_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pokey_clock_scheduler_if bus ();

  pokey_clock_scheduler #(.DIV_64(28), .DIV_15(114)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] v;   // {tick_64, tick_15, base_tick, chan_enable[3:0], delay_sync_reset}
    string      name;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int          ce_cnt = 0;   // ce ticks seen since last reset / init

  logic       g_rst    = 1'b0;
  logic       g_init   = 1'b0;
  logic [7:0] g_audctl = 8'h00;
  string      g_name   = "reset";

  function automatic logic [3:0] en_of(input logic [7:0] a, input logic b, input logic [3:0] uf);
    logic [3:0] r;
    r[0] = a[6] ? 1'b1  : b;
    r[1] = a[4] ? uf[0] : b;
    r[2] = a[5] ? 1'b1  : b;
    r[3] = a[3] ? uf[2] : b;
    return r;
  endfunction

  // One clk of stimulus; stim_dsr = clear expected from a pending STIMER,
  // blk = chan_enable expected suppressed by that pending STIMER.
  task automatic cyc(input logic c, input logic sw, input logic [3:0] uf,
                     input logic stim_dsr, input logic blk);
    logic t64, t15, base, act, dsr;
    logic [3:0] en;
    exp_t e;
    @(posedge clk);
    #1;
    reset_n       = g_rst;
    bus.init_mode = g_init;
    bus.audctl    = g_audctl;
    bus.ce        = c;
    bus.stimer_wr = sw;
    bus.underflow = uf;
    act = c && g_rst && !g_init;
    if (!g_rst || g_init) ce_cnt = 0;
    else if (c) ce_cnt++;
    t64  = act && (ce_cnt % 28 == 0);
    t15  = act && (ce_cnt % 114 == 0);
    base = g_audctl[0] ? t15 : t64;
    en   = (act && !blk) ? en_of(g_audctl, base, uf) : 4'b0000;
    dsr  = !g_rst || g_init || stim_dsr;
    e.v    = {t64, t15, base, en, dsr};
    e.name = g_name;
    q.push_back(e);
  endtask

  task automatic run_ce(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
      for (int j = 1; j < gap; j++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest expected entry.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = q.pop_front();
      got = {bus.tick_64, bus.tick_15, bus.base_tick, bus.chan_enable, bus.delay_sync_reset};
      checks++;
      if (got === e.v) passed++;
      else $display("FAIL %s @%0t: got t64/t15/base/en/dsr=%b want %b", e.name, $time, got, e.v);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ce        = 1'b0;
    bus.init_mode = 1'b0;
    bus.audctl    = 8'h00;
    bus.stimer_wr = 1'b0;
    bus.underflow = 4'b0000;

    // Reset: outputs forced low, clear high, even with ce toggling.
    g_name = "reset";
    for (int i = 0; i < 4; i++) cyc(i[0], 1'b0, 4'b0000, 1'b0, 1'b0);
    g_rst = 1'b1;

    // Base ticks, ce every 2 clk.
    g_name = "base_ticks";
    g_audctl = 8'h00;
    run_ce(230, 2);

    // Source select: ch0/ch2 at 1.79 MHz, ch1/ch3 on the 15 kHz base.
    g_name = "source_sel";
    g_audctl = 8'h61;
    run_ce(120, 2);

    // Join: ch1 follows underflow[0], ch3 follows underflow[2], only with ce.
    g_name = "join";
    g_audctl = 8'h58;
    cyc(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);
    run_ce(30, 2);

    // STIMER 3 clk before a tick_64 ce: clear for 3 clk, enables blocked.
    g_audctl = 8'h00;
    g_name = "stimer_align";
    while (ce_cnt % 28 != 27) run_ce(1, 2);
    g_name = "stimer";
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    g_name = "stimer_after";
    run_ce(28, 2);
    // STIMER coinciding with ce: set wins, clears on the following ce.
    g_name = "stimer_coincide";
    cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Init mode for 50 ce, then release; first tick_64 on 28th ce.
    g_name = "init";
    g_init = 1'b1;
    run_ce(50, 2);
    g_name = "init_release";
    g_init = 1'b0;
    run_ce(60, 2);

    // Reset asserted with cnt64 = 17; counting restarts from 0 afterwards.
    g_name = "reset_align";
    while (ce_cnt % 28 != 17) run_ce(1, 2);
    g_name = "reset_mid";
    g_rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    g_name = "reset_release";
    g_rst = 1'b1;
    run_ce(60, 2);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left want 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
